rr_arbiter_hold: RTL

//   Parametrised N-way round-robin arbiter for shared-resource access.

---
 rtl/rr_arbiter_hold.sv | 105 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with one-hot grant, bounded grant hold and rotating priority.
// Latency: req sampled at a clock edge is reflected on gnt/gnt_id/gnt_valid right after that edge.
// Backpressure: none; a holder keeps gnt until it drops req or exhausts MAX_HOLD while others wait.
module rr_arbiter_hold #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4,
   localparam int IDW     = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid
);

   localparam int             HW   = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]  HMAX = HW'(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;       // highest-priority index for the next search
   logic [HW-1:0]  hcnt;      // cycles the current grant has been held
   logic [N-1:0]   cand;      // requesters eligible to win a new grant
   logic           pick_vld;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] pick_nxt;

   // Find the first eligible requester starting at ptr; the current holder is
   // never eligible, which makes it the last in line after its hold expires.
   always_comb begin
      cand     = req;
      pick_vld = 1'b0;
      pick_id  = '0;
      if (state == GRANT) begin
         cand[gnt_id] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         logic [IDW:0]   sum;
         logic [IDW-1:0] idx;
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
         end
         idx = sum[IDW-1:0];
         if (!pick_vld && cand[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
      pick_nxt = (pick_id == IDW'(N-1)) ? '0 : pick_id + IDW'(1);
   end

   // Grant FSM: all outputs registered, priority rotates past each new winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         ptr       <= '0;
         hcnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state     <= GRANT;
                  gnt       <= N'(1) << pick_id;
                  gnt_id    <= pick_id;
                  gnt_valid <= 1'b1;
                  ptr       <= pick_nxt;
                  hcnt      <= HW'(1);
               end
            end
            GRANT: begin
               if (!req[gnt_id] || (hcnt == HMAX && pick_vld)) begin
                  // Holder released, or its hold expired with someone waiting.
                  if (pick_vld) begin
                     gnt    <= N'(1) << pick_id;
                     gnt_id <= pick_id;
                     ptr    <= pick_nxt;
                     hcnt   <= HW'(1);
                  end else begin
                     state     <= IDLE;
                     gnt       <= '0;
                     gnt_id    <= '0;
                     gnt_valid <= 1'b0;
                     hcnt      <= '0;
                  end
               end else if (hcnt < HMAX) begin
                  hcnt <= hcnt + HW'(1);
               end else begin
                  // Lone holder at the limit: keep the grant, restart its count.
                  hcnt <= HW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
